// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: applies D-stage branch/jump redirects with one delay slot,
// parks targets while fetch is busy, and keeps saturating branch statistics.
module branch_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_ready,
   input  logic             stall,
   input  logic             d_valid,
   input  logic [2:0]       d_brop,
   input  logic [31:0]      d_pc,
   input  logic [25:0]      d_imm26,
   input  logic [31:0]      d_rs,
   input  logic             cmp_result,
   output logic [31:0]      f_pc,
   output logic             f_valid,
   output logic             redirect,
   output logic             nullify,
   output logic [CNT_W-1:0] br_total_cnt,
   output logic [CNT_W-1:0] br_taken_cnt
);

   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t            state, state_n;
   logic [31:0]       pend_pc, pend_n, pc_n;
   logic              redir_n;
   logic [CNT_W-1:0]  tot_n, tkn_n;
   logic              is_br, is_any, res, taken;
   logic [31:0]       p4, br_tgt, j_tgt, target;

   always_comb begin
      is_br  = (d_brop == 3'b001) || (d_brop == 3'b010);
      is_any = is_br || (d_brop == 3'b011) || (d_brop == 3'b100);
      res    = d_valid & ~stall & (state == RUN) & is_any;
      taken  = is_br ? cmp_result : 1'b1;
      p4     = d_pc + 32'd4;
      br_tgt = p4 + {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
      j_tgt  = {p4[31:28], d_imm26, 2'b00};
      unique case (d_brop)
         3'b011:  target = j_tgt;
         3'b100:  target = d_rs;
         default: target = br_tgt;
      endcase
      nullify = res & (d_brop == 3'b010) & ~cmp_result;
   end

   always_comb begin
      state_n = state;
      pc_n    = f_pc;
      pend_n  = pend_pc;
      redir_n = 1'b0;
      unique case (state)
         RUN: begin
            if (res && taken) begin
               if (if_ready) begin
                  pc_n    = target;
                  redir_n = 1'b1;
               end else begin
                  pend_n  = target;
                  state_n = HOLD;
               end
            end else if (if_ready && !stall) begin
               pc_n = f_pc + 32'd4;
            end
         end
         HOLD: begin
            // stall deliberately does not block draining the parked target
            if (if_ready) begin
               pc_n    = pend_pc;
               redir_n = 1'b1;
               state_n = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      tot_n = br_total_cnt;
      tkn_n = br_taken_cnt;
      if (res && is_br) begin
         if (br_total_cnt != '1) tot_n = br_total_cnt + ONE;
         if (taken && br_taken_cnt != '1) tkn_n = br_taken_cnt + ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= RUN;
         f_pc         <= RESET_PC;
         pend_pc      <= 32'd0;
         f_valid      <= 1'b0;
         redirect     <= 1'b0;
         br_total_cnt <= '0;
         br_taken_cnt <= '0;
      end else begin
         state        <= state_n;
         f_pc         <= pc_n;
         pend_pc      <= pend_n;
         f_valid      <= 1'b1;
         redirect     <= redir_n;
         br_total_cnt <= tot_n;
         br_taken_cnt <= tkn_n;
      end
   end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomised and directed bench for branch_redirect_unit against a
// rule-level fetch PC model; a second instance uses 2-bit counters.
module tb_branch_redirect_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_ready = 1'b1;
   logic        stall = 1'b0;
   logic        d_valid = 1'b0;
   logic [2:0]  d_brop = 3'b000;
   logic [31:0] d_pc = 32'd0;
   logic [25:0] d_imm26 = 26'd0;
   logic [31:0] d_rs = 32'd0;
   logic        cmp_result = 1'b0;

   logic [31:0] f_pc, s_f_pc;
   logic        f_valid, redirect, nullify;
   logic        s_f_valid, s_redirect, s_nullify;
   logic [15:0] br_total_cnt, br_taken_cnt;
   logic [1:0]  s_total, s_taken;

   int n_cmp = 0;
   int n_bad = 0;

   branch_redirect_unit u_dut (
      .clk(clk), .reset(reset), .if_ready(if_ready), .stall(stall),
      .d_valid(d_valid), .d_brop(d_brop), .d_pc(d_pc),
      .d_imm26(d_imm26), .d_rs(d_rs), .cmp_result(cmp_result),
      .f_pc(f_pc), .f_valid(f_valid), .redirect(redirect),
      .nullify(nullify), .br_total_cnt(br_total_cnt),
      .br_taken_cnt(br_taken_cnt)
   );

   branch_redirect_unit #(.CNT_W(2)) u_small (
      .clk(clk), .reset(reset), .if_ready(if_ready), .stall(stall),
      .d_valid(d_valid), .d_brop(d_brop), .d_pc(d_pc),
      .d_imm26(d_imm26), .d_rs(d_rs), .cmp_result(cmp_result),
      .f_pc(s_f_pc), .f_valid(s_f_valid), .redirect(s_redirect),
      .nullify(s_nullify), .br_total_cnt(s_total),
      .br_taken_cnt(s_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: fetch PC, a parked target (if any) and plain integer counters
   logic [31:0] m_pc = 32'h0000_3000;
   logic [31:0] m_pend = 32'd0;
   bit          m_hold = 0;
   bit          m_valid = 0;
   bit          m_redir = 0;
   int          m_tot = 0, m_tkn = 0;
   int          m_tot2 = 0, m_tkn2 = 0;

   function automatic bit m_res();
      return d_valid && !stall && !m_hold && d_brop >= 3'd1 && d_brop <= 3'd4;
   endfunction

   function automatic logic [31:0] m_target();
      logic [31:0] p4;
      int          off;
      p4 = d_pc + 32'd4;
      if (d_brop == 3'd3) return {p4[31:28], d_imm26, 2'b00};
      if (d_brop == 3'd4) return d_rs;
      off = 4 * int'($signed(d_imm26[15:0]));
      return p4 + 32'(off);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = 32'h0000_3000; m_pend = 0; m_hold = 0; m_valid = 0;
         m_redir = 0; m_tot = 0; m_tkn = 0; m_tot2 = 0; m_tkn2 = 0;
      end else begin
         bit r, tk, cond;
         r    = m_res();
         cond = (d_brop == 3'd1) || (d_brop == 3'd2);
         tk   = !cond || cmp_result;
         if (r && cond) begin
            m_tot  = (m_tot < 65535) ? m_tot + 1 : m_tot;
            m_tot2 = (m_tot2 < 3) ? m_tot2 + 1 : m_tot2;
            if (tk) begin
               m_tkn  = (m_tkn < 65535) ? m_tkn + 1 : m_tkn;
               m_tkn2 = (m_tkn2 < 3) ? m_tkn2 + 1 : m_tkn2;
            end
         end
         m_valid = 1;
         m_redir = 0;
         if (m_hold) begin
            if (if_ready) begin
               m_pc = m_pend; m_redir = 1; m_hold = 0;
            end
         end else if (r && tk) begin
            if (if_ready) begin
               m_pc = m_target(); m_redir = 1;
            end else begin
               m_pend = m_target(); m_hold = 1;
            end
         end else if (if_ready && !stall) begin
            m_pc = m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      #2;
      chk("f_pc", f_pc, m_pc);
      chk("f_valid", 32'(f_valid), 32'(m_valid));
      chk("redirect", 32'(redirect), 32'(m_redir));
      chk("nullify", 32'(nullify),
          32'(m_res() && d_brop == 3'd2 && !cmp_result));
      chk("total", 32'(br_total_cnt), 32'(m_tot));
      chk("taken", 32'(br_taken_cnt), 32'(m_tkn));
      chk("s_f_pc", s_f_pc, m_pc);
      chk("s_total", 32'(s_total), 32'(m_tot2));
      chk("s_taken", 32'(s_taken), 32'(m_tkn2));
   end

   task automatic br(input logic [2:0] op, input logic [31:0] pc,
                     input logic [25:0] imm, input logic c);
      d_valid = 1'b1; d_brop = op; d_pc = pc; d_imm26 = imm; cmp_result = c;
   endtask

   initial begin
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pc", f_pc, 32'h3000);
      chk("rst_valid", 32'(f_valid), 0);
      chk("rst_redir", 32'(redirect), 0);
      chk("rst_cnt", 32'(br_total_cnt), 0);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("rel_pc", f_pc, 32'h3000);
      chk("rel_valid", 32'(f_valid), 0);
      @(negedge clk);
      chk("seq1", f_pc, 32'h3004);
      chk("seq1_valid", 32'(f_valid), 1);
      @(negedge clk);
      chk("seq2", f_pc, 32'h3008);

      br(3'b001, 32'h3004, 26'h000FFFF, 1'b1);
      @(negedge clk);
      d_valid = 1'b0;
      chk("br_pc", f_pc, 32'h3004);
      chk("br_redir", 32'(redirect), 1);
      chk("br_tkn", 32'(br_taken_cnt), 1);
      chk("br_tot", 32'(br_total_cnt), 1);
      @(negedge clk);
      chk("br_after", f_pc, 32'h3008);
      chk("br_pulse", 32'(redirect), 0);

      br(3'b011, 32'h3010, 26'h0000C10, 1'b0);
      if_ready = 1'b0;
      @(negedge clk);
      d_valid = 1'b0;
      chk("j_hold0", f_pc, 32'h3008);
      repeat (2) @(negedge clk);
      chk("j_hold2", f_pc, 32'h3008);
      chk("j_noredir", 32'(redirect), 0);
      if_ready = 1'b1;
      @(negedge clk);
      chk("j_pc", f_pc, 32'h3040);
      chk("j_redir", 32'(redirect), 1);
      @(negedge clk);
      chk("j_after", f_pc, 32'h3044);

      br(3'b010, 32'h3040, 26'h0000010, 1'b0);
      #1 chk("nul_on", 32'(nullify), 1);
      @(negedge clk);
      chk("nul_pc", f_pc, 32'h3048);
      chk("nul_tkn", 32'(br_taken_cnt), 1);
      chk("nul_tot", 32'(br_total_cnt), 2);
      stall = 1'b1;
      #1 chk("nul_stall", 32'(nullify), 0);
      @(negedge clk);
      stall = 1'b0;
      d_valid = 1'b0;
      chk("stall_pc", f_pc, 32'h3048);
      chk("stall_tot", 32'(br_total_cnt), 2);

      br(3'b100, 32'h3048, 26'd0, 1'b0);
      d_rs = 32'h0000_ABC0;
      if_ready = 1'b0;
      @(negedge clk);
      d_valid = 1'b0;
      chk("jr_park", f_pc, 32'h3048);
      #1 reset = 1'b0;
      #1 chk("jr_rst_pc", f_pc, 32'h3000);
      chk("jr_rst_valid", 32'(f_valid), 0);
      @(negedge clk);
      reset = 1'b1;
      if_ready = 1'b1;
      @(negedge clk);
      chk("jr_cleared", f_pc, 32'h3004);
      chk("jr_noredir", 32'(redirect), 0);

      for (int i = 0; i < 4; i++) begin
         br(3'b001, 32'h3100, 26'd4, 1'b1);
         @(negedge clk);
      end
      d_valid = 1'b0;
      chk("sat_tot2", 32'(s_total), 3);
      chk("sat_tkn2", 32'(s_taken), 3);
      chk("sat_tot16", 32'(br_total_cnt), 4);

      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 299) != 0);
         if_ready   = ($urandom_range(0, 9) < 7);
         stall      = ($urandom_range(0, 9) < 2);
         d_valid    = ($urandom_range(0, 9) < 7);
         d_brop     = 3'($urandom_range(0, 7));
         d_pc       = $urandom;
         d_imm26    = 26'($urandom);
         d_rs       = $urandom;
         cmp_result = 1'($urandom);
         @(negedge clk);
      end
      reset = 1'b1;
      d_valid = 1'b0;
      @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
